// File: rtl/tdot_pkg.sv
// Shared types and sizing for the tdot loader: element width, lane count,
// lane index type and the FILL/FULL state encoding.
package tdot_pkg;
  localparam int unsigned W       = 8;
  localparam int unsigned LANES   = 3;
  localparam int unsigned LANE_IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic signed [W-1:0] elem_t;
  typedef logic [LANE_IW-1:0]  lane_idx_t;

  typedef enum logic {FILL, FULL} state_t;
endpackage

// File: rtl/tdot_lane_buf.sv
// LANES x W lane register file; one lane written per enable, with an optional
// clear of every other lane so a fresh group never inherits stale data.
module tdot_lane_buf
  import tdot_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic               clr,
  input  lane_idx_t          idx,
  input  logic [W-1:0]       d,
  output logic [LANES*W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (we) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (k == 32'(idx))
          q[k*W +: W] <= d;
        else if (clr)
          q[k*W +: W] <= '0;
      end
    end
  end

endmodule

// File: rtl/tdot_loader.sv
// Packs a serial stream of (a,b) pairs plus a bias into parallel lanes for the
// tdot datapath; short groups closed by in_last are zero-padded.
module tdot_loader
  import tdot_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [W-1:0]       in_c,
  input  logic               in_last,
  output logic [LANES*W-1:0] out_a,
  output logic [LANES*W-1:0] out_b,
  output logic [W-1:0]       out_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               en,
  output logic [31:0]        groups
);

  localparam lane_idx_t LAST = lane_idx_t'(LANES - 1);

  state_t    state, state_nx;
  lane_idx_t idx;
  logic      in_fire;
  logic      first;
  logic      complete;

  assign in_fire  = in_valid & in_ready;
  assign first    = (idx == '0);
  assign complete = in_fire & ((idx == LAST) | in_last);

  always_ff @(posedge clock) begin
    if (reset) state <= FILL;
    else       state <= state_nx;
  end

  // A completing pair takes priority so a same-cycle consume keeps out_valid high.
  always_comb begin
    state_nx = state;
    if (complete)
      state_nx = FULL;
    else if (en)
      state_nx = FILL;
  end

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = ~out_valid | out_ready;
    en        = out_valid & out_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx    <= '0;
      out_c  <= '0;
      groups <= '0;
    end else begin
      if (in_fire) begin
        idx <= complete ? '0 : idx + lane_idx_t'(1);
        if (first)
          out_c <= in_c;
      end
      if (en)
        groups <= groups + 32'd1;
    end
  end

  tdot_lane_buf u_buf_a (
    .clock (clock),
    .reset (reset),
    .we    (in_fire),
    .clr   (first),
    .idx   (idx),
    .d     (in_a),
    .q     (out_a)
  );

  tdot_lane_buf u_buf_b (
    .clock (clock),
    .reset (reset),
    .we    (in_fire),
    .clr   (first),
    .idx   (idx),
    .d     (in_b),
    .q     (out_b)
  );

endmodule

// File: tb/tb_tdot_loader.sv
// Directed bench for tdot_loader: grouping, padding, backpressure, streaming,
// mid-group reset and idle gaps, with a downstream dot-product model.
module tb_tdot_loader;
  import tdot_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_a, in_b, in_c;
  logic               in_last;
  logic [LANES*W-1:0] out_a, out_b;
  logic [W-1:0]       out_c;
  logic               out_valid;
  logic               out_ready;
  logic               en;
  logic [31:0]        groups;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  tdot_loader dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_last   (in_last),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .en        (en),
    .groups    (groups)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream tdot result for whatever group is currently presented.
  function automatic int y_of();
    int acc;
    acc = int'(elem_t'(out_c));
    for (int k = 0; k < int'(LANES); k++)
      acc += int'(elem_t'(out_a[k*W +: W])) * int'(elem_t'(out_b[k*W +: W]));
    return acc;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one pair and return #1 after the edge on which it was accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic last);
    int unsigned t;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_c      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_groups",    64'(groups),    64'd0);
    check("rst_out_a",     64'(out_a),     64'd0);
    check("rst_out_c",     64'(out_c),     64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);

    // 1. full group
    send(8'hFD, 8'd8, 8'd10, 1'b0);
    check("t1_not_yet", 64'(out_valid), 64'd0);
    send(8'd28, 8'd1, 8'd99, 1'b0);
    send(8'd1,  8'd3, 8'd99, 1'b0);
    idle();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_en",    64'(en),        64'd1);
    check("t1_out_a", 64'(out_a),     64'h011CFD);
    check("t1_out_b", 64'(out_b),     64'h030108);
    check("t1_out_c", 64'(out_c),     64'd10);
    check("t1_y",     64'(y_of()),    64'd17);
    tick();
    check("t1_en_once", 64'(en),     64'd0);
    check("t1_groups",  64'(groups), 64'd1);

    // 2. early last on lane 0, then a full group, then a 2-lane group
    send(8'd5, 8'd2, 8'd1, 1'b1);
    idle();
    check("t2_out_a", 64'(out_a), 64'h000005);
    check("t2_out_b", 64'(out_b), 64'h000002);
    check("t2_out_c", 64'(out_c), 64'd1);
    check("t2_y",     64'(y_of()), 64'd11);
    tick();
    send(8'd1, 8'd1, 8'd0, 1'b0);
    send(8'd2, 8'd2, 8'd0, 1'b0);
    send(8'd3, 8'd3, 8'd0, 1'b0);
    idle();
    check("t2_full_a", 64'(out_a), 64'h030201);
    check("t2_full_y", 64'(y_of()), 64'd14);
    tick();
    send(8'd7,  8'd1, 8'd2, 1'b0);
    send(8'hFF, 8'd4, 8'd0, 1'b1);
    idle();
    check("t2_pad_a", 64'(out_a), 64'h00FF07);
    check("t2_pad_b", 64'(out_b), 64'h000401);
    check("t2_pad_y", 64'(y_of()), 64'd5);
    tick();
    check("t2_groups", 64'(groups), 64'd4);

    // 3. backpressure with the next pair already waiting
    out_ready = 1'b0;
    send(8'd1, 8'd2, 8'd4, 1'b0);
    send(8'd3, 8'd4, 8'd0, 1'b0);
    send(8'd5, 8'd6, 8'd0, 1'b0);
    in_valid = 1'b1;
    in_a = 8'd9; in_b = 8'd9; in_c = 8'd7; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_in_ready", 64'(in_ready),  64'd0);
      check("t3_valid",    64'(out_valid), 64'd1);
      check("t3_out_a",    64'(out_a),     64'h050301);
      check("t3_groups",   64'(groups),    64'd4);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t3_en",       64'(en),       64'd1);
    check("t3_in_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    check("t3_groups_inc", 64'(groups),    64'd5);
    check("t3_drained",    64'(out_valid), 64'd0);
    send(8'd8, 8'd8, 8'd99, 1'b0);
    send(8'd7, 8'd7, 8'd99, 1'b0);
    idle();
    check("t3_next_a", 64'(out_a), 64'h070809);
    check("t3_next_c", 64'(out_c), 64'd7);
    check("t3_next_y", 64'(y_of()), 64'd201);
    tick();

    // 4. streaming, 12 pairs back to back
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_a     = 8'(i + 1);
      in_b     = 8'd1;
      in_c     = (i % 3 == 0) ? 8'(i) : 8'd99;
      in_last  = 1'b0;
      #1;
      check("t4_in_ready", 64'(in_ready), 64'd1);
      tick();
      check("t4_en", 64'(en), (i % 3 == 2) ? 64'd1 : 64'd0);
      if (i % 3 == 2) begin
        check("t4_out_a", 64'(out_a), 64'({8'(i + 1), 8'(i), 8'(i - 1)}));
        check("t4_out_c", 64'(out_c), 64'(i - 2));
      end
    end
    idle();
    tick();
    check("t4_groups", 64'(groups), 64'd10);

    // 5. reset mid-group
    send(8'd50, 8'd50, 8'd9, 1'b0);
    send(8'd51, 8'd51, 8'd9, 1'b0);
    idle();
    reset = 1'b1;
    tick();
    check("t5_rst_valid",  64'(out_valid), 64'd0);
    check("t5_rst_groups", 64'(groups),    64'd0);
    reset = 1'b0;
    tick();
    check("t5_post_valid",  64'(out_valid), 64'd0);
    check("t5_post_groups", 64'(groups),    64'd0);
    send(8'd2, 8'd3, 8'd1, 1'b0);
    send(8'd4, 8'd5, 8'd0, 1'b0);
    check("t5_not_yet", 64'(out_valid), 64'd0);
    send(8'd6, 8'd7, 8'd0, 1'b0);
    idle();
    check("t5_out_a", 64'(out_a), 64'h060402);
    check("t5_out_c", 64'(out_c), 64'd1);
    check("t5_y",     64'(y_of()), 64'd69);
    tick();
    check("t5_groups", 64'(groups), 64'd1);

    // 6. idle gaps between accepted pairs
    send(8'hFD, 8'd8, 8'd10, 1'b0);
    idle();
    tick();
    check("t6_gap1", 64'(out_valid), 64'd0);
    send(8'd28, 8'd1, 8'd99, 1'b0);
    idle();
    tick();
    check("t6_gap2", 64'(out_valid), 64'd0);
    send(8'd1, 8'd3, 8'd99, 1'b0);
    idle();
    check("t6_valid", 64'(out_valid), 64'd1);
    check("t6_out_a", 64'(out_a), 64'h011CFD);
    check("t6_out_b", 64'(out_b), 64'h030108);
    check("t6_y",     64'(y_of()), 64'd17);
    tick();
    check("t6_groups", 64'(groups), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
